lzc_norm_pipe: RTL and testbench
================================

Name: lzc_norm_pipe

Overview:
- Parametrised, pipelined leading-zero counter plus left-shift normaliser for PE accumulator results in the systolic array.
- Takes an unnormalised mantissa with an unsigned biased exponent and produces the leading-zero count, the normalised mantissa (MSB = 1) and the adjusted exponent.
- Two register stages with valid/ready flow control; replaces fixed-width combinational LZ detection at the array edge.

Parameters:
- WIDTH, 16, mantissa width; power of two, 4..64.
- EXP_W, 8, exponent width (unsigned).
- TAG_W, 4, sideband tag carried unchanged alongside the data.
- CNT_W, $clog2(WIDTH)+1, count width (derived, not overridden); must hold the value WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_mant  in  WIDTH  unnormalised mantissa.
- in_exp  in  EXP_W  exponent.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_mant  out  WIDTH  normalised mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- out_lz  out  CNT_W  leading-zero count.
- out_zero  out  1  input mantissa was all zero.
- out_uflow  out  1  in_exp < leading-zero count (non-zero input only).
- out_tag  out  TAG_W  tag of this beat.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid flags = 0, so out_valid = 0 and in_ready = 1 after reset. All data registers clear to 0 (out_mant, out_exp, out_lz, out_zero, out_uflow, out_tag = 0).
- Stage S1 (on input handshake):
  - Registers in_mant, in_exp and in_tag.
  - Registers lz = number of zeros above the highest set bit (0..WIDTH-1).
  - Registers zero = ~|in_mant. For zero input, lz = WIDTH.
- Stage S2 (on S1→S2 advance):
  - out_mant = mant << lz, truncated to WIDTH.
  - out_exp = exp - lz, modulo 2^EXP_W.
  - out_uflow = ~zero & (exp < lz).
  - Zero input: out_mant = 0, out_exp = 0, out_uflow = 0, out_lz = WIDTH.
- Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 beat/cycle.
- Flow control:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no bubbles).
- Stall: while out_valid & ~out_ready, all output ports hold stable. in_ready drops once both stages are full.
- Simultaneous events: an output handshake and an input handshake in the same cycle both complete. Occupancy is unchanged and no beat is lost or duplicated.
- Ordering: strict FIFO order; tag always travels with its own data.
- Reset mid-operation: in-flight beats are discarded and not replayed.

Optional Feature:
- Macro: LZN_FTZ_EN.
- Defined: on underflow, out_mant = 0 and out_exp = 0; out_uflow = 1 and out_lz is still the true count.
- Undefined: on underflow, out_exp wraps modulo 2^EXP_W and out_mant is the normal shifted value; out_uflow = 1.

Decomposition:
- Package lzn_pkg holds the clog2 helper function and the CNT_W derivation rule.
- Package also holds a localparam for the zero-input count value (WIDTH).
- Sub-module lzc_tree (combinational, parametrised WIDTH):
  - Recursive halves; upper-half valid selects the upper count, otherwise the lower count with the MSB of the count set.
  - Outputs any-set flag plus count.
  - Instantiated once in S1.

Test Plan (WIDTH=16, EXP_W=8):
- Single beat: in_mant=16'h0123, exp=20, tag=3, out_ready=1 → 2 cycles later out_lz=7, out_mant=16'h9180, out_exp=13, uflow=0, zero=0, tag=3.
- Zero input: in_mant=0, exp=50 → out_zero=1, out_lz=16, out_mant=0, out_exp=0, uflow=0.
- Underflow: in_mant=16'h0001, exp=10 → out_lz=15, uflow=1.
  - With LZN_FTZ_EN: out_mant=0, out_exp=0.
  - Without: out_mant=16'h8000, out_exp=8'hFB.
- Back-pressure: stream 6 beats (tags 0..5) with out_ready held 0 for 5 cycles → in_ready=0 after 2 accepted. Outputs hold tag 0 stable. After release, tags 0..5 arrive in order with none lost or duplicated.
- Full throughput: 100 random beats with in_valid=1 and out_ready=1 → one output per cycle, every result matches the reference model, and in_ready never drops.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight → out_valid=0 immediately, in_ready=1 after release, no stale beat emitted.

Source files
------------

// File: rtl/lzn_pkg.sv
// Shared definitions for the leading-zero normaliser pipeline:
// clog2 helper, count-width derivation and the zero-input count rule.
package lzn_pkg;

    // Default configuration of the normaliser at the array edge.
    localparam int LZN_WIDTH = 16;
    localparam int LZN_EXP_W = 8;
    localparam int LZN_TAG_W = 4;

    // An all-zero mantissa reports a count equal to the full width.
    localparam int LZN_ZERO_LZ = LZN_WIDTH;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // The count must be able to represent WIDTH itself (zero input).
    function automatic int cnt_width(input int width);
        return clog2(width) + 1;
    endfunction

    function automatic int zero_lz(input int width);
        return width;
    endfunction

endpackage

// File: rtl/lzc_norm_pipe_if.sv
// Stream interface of the normaliser: input beat (mantissa/exponent/tag)
// and normalised output beat, each with valid/ready handshake.
interface lzc_norm_pipe_if
    import lzn_pkg::*;
#(
    parameter int WIDTH = LZN_WIDTH,
    parameter int EXP_W = LZN_EXP_W,
    parameter int TAG_W = LZN_TAG_W,
    parameter int CNT_W = cnt_width(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [EXP_W-1:0] in_exp;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic [EXP_W-1:0] out_exp;
    logic [CNT_W-1:0] out_lz;
    logic             out_zero;
    logic             out_uflow;
    logic [TAG_W-1:0] out_tag;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_mant, in_exp, in_tag, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_lz,
               out_zero, out_uflow, out_tag
    );

    // Normaliser side.
    modport slave (
        input  in_valid, in_mant, in_exp, in_tag, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_lz,
               out_zero, out_uflow, out_tag
    );
endinterface

// File: rtl/lzc_norm_pipe_lzc_tree.sv
// Combinational leading-zero counter built as a tree of halves: each node
// takes the upper-half count when the upper half has a set bit, otherwise
// the lower-half count with the node's count MSB set.
module lzc_tree
    import lzn_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int LOG = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_bits,
    output logic             any_set,
    output logic [LOG-1:0]   count
);
    genvar gl, gi;

    for (gl = 0; gl < LOG; gl++) begin : lvl
        localparam int N = WIDTH >> (gl + 1);
        logic [N-1:0] any_v;
        logic [gl:0]  cnt_v [N];

        for (gi = 0; gi < N; gi++) begin : node
            if (gl == 0) begin : leaf
                assign any_v[gi] = in_bits[2*gi+1] | in_bits[2*gi];
                assign cnt_v[gi] = ~in_bits[2*gi+1];
            end else begin : merge
                assign any_v[gi] = lvl[gl-1].any_v[2*gi+1] | lvl[gl-1].any_v[2*gi];
                assign cnt_v[gi] = lvl[gl-1].any_v[2*gi+1]
                                 ? {1'b0, lvl[gl-1].cnt_v[2*gi+1]}
                                 : {1'b1, lvl[gl-1].cnt_v[2*gi]};
            end
        end
    end

    assign any_set = lvl[LOG-1].any_v[0];
    assign count   = lvl[LOG-1].cnt_v[0];
endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero count + left-shift normaliser with valid/ready.
// S1 registers the beat and its leading-zero count, S2 shifts and adjusts
// the exponent. Optional flush-to-zero on underflow: define LZN_FTZ_EN.
module lzc_norm_pipe
    import lzn_pkg::*;
#(
    parameter int WIDTH = LZN_WIDTH,
    parameter int EXP_W = LZN_EXP_W,
    parameter int TAG_W = LZN_TAG_W
) (
    input  logic            clk,
    input  logic            rst_n,
    lzc_norm_pipe_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int LOG   = CNT_W - 1;
    localparam int CMP_W = (EXP_W > CNT_W) ? EXP_W : CNT_W;
    localparam logic [CNT_W-1:0] ZERO_LZ = CNT_W'(zero_lz(WIDTH));

    logic             s1_valid_reg, s2_valid_reg;
    logic [WIDTH-1:0] s1_mant_reg,  s2_mant_reg;
    logic [EXP_W-1:0] s1_exp_reg,   s2_exp_reg;
    logic [TAG_W-1:0] s1_tag_reg,   s2_tag_reg;
    logic [CNT_W-1:0] s1_lz_reg,    s2_lz_reg;
    logic             s1_zero_reg,  s2_zero_reg;
    logic             s2_uflow_reg;

    logic             lz_any;
    logic [LOG-1:0]   lz_cnt;
    logic [CNT_W-1:0] s1_lz_next;
    logic [WIDTH-1:0] s2_mant_next;
    logic [EXP_W-1:0] s2_exp_next;
    logic             s2_uflow_next;
    logic             s1_adv, s2_adv;

    // Each stage may advance when empty or when the stage after it drains.
    assign s2_adv       = ~s2_valid_reg | bus.out_ready;
    assign s1_adv       = ~s1_valid_reg | s2_adv;
    assign bus.in_ready = s1_adv;

    lzc_tree #(.WIDTH(WIDTH)) u_lzc_tree (
        .in_bits (bus.in_mant),
        .any_set (lz_any),
        .count   (lz_cnt)
    );

    assign s1_lz_next = lz_any ? {1'b0, lz_cnt} : ZERO_LZ;

    // S1: capture the beat together with its leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mant_reg  <= '0;
            s1_exp_reg   <= '0;
            s1_tag_reg   <= '0;
            s1_lz_reg    <= '0;
            s1_zero_reg  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_mant_reg <= bus.in_mant;
                s1_exp_reg  <= bus.in_exp;
                s1_tag_reg  <= bus.in_tag;
                s1_lz_reg   <= s1_lz_next;
                s1_zero_reg <= ~lz_any;
            end
        end
    end

    // S2 datapath: normalise, adjust the exponent and flag underflow.
    always_comb begin
        s2_mant_next  = s1_mant_reg << s1_lz_reg;
        s2_exp_next   = s1_exp_reg - EXP_W'(s1_lz_reg);
        s2_uflow_next = ~s1_zero_reg & (CMP_W'(s1_exp_reg) < CMP_W'(s1_lz_reg));
        if (s1_zero_reg) begin
            s2_mant_next  = '0;
            s2_exp_next   = '0;
            s2_uflow_next = 1'b0;
        end
`ifdef LZN_FTZ_EN
        if (s2_uflow_next) begin
            s2_mant_next = '0;
            s2_exp_next  = '0;
        end
`endif
    end

    // S2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_mant_reg  <= '0;
            s2_exp_reg   <= '0;
            s2_tag_reg   <= '0;
            s2_lz_reg    <= '0;
            s2_zero_reg  <= 1'b0;
            s2_uflow_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_mant_reg  <= s2_mant_next;
                s2_exp_reg   <= s2_exp_next;
                s2_tag_reg   <= s1_tag_reg;
                s2_lz_reg    <= s1_lz_reg;
                s2_zero_reg  <= s1_zero_reg;
                s2_uflow_reg <= s2_uflow_next;
            end
        end
    end

    assign bus.out_valid = s2_valid_reg;
    assign bus.out_mant  = s2_mant_reg;
    assign bus.out_exp   = s2_exp_reg;
    assign bus.out_lz    = s2_lz_reg;
    assign bus.out_zero  = s2_zero_reg;
    assign bus.out_uflow = s2_uflow_reg;
    assign bus.out_tag   = s2_tag_reg;
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Self-checking bench for lzc_norm_pipe (WIDTH=16, EXP_W=8, TAG_W=4).
// A scoreboard queue holds results computed from the arithmetic definition
// of normalisation; directed tests add fixed expected values.
module tb_lzc_norm_pipe;
    typedef struct {
        logic [15:0] mant;
        logic [7:0]  exp;
        logic [4:0]  lz;
        logic        zero;
        logic        uflow;
        logic [3:0]  tag;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lzc_norm_pipe_if #(.WIDTH(16), .EXP_W(8), .TAG_W(4)) bus ();

    lzc_norm_pipe #(.WIDTH(16), .EXP_W(8), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   tests_run = 0;
    int   tests_failed = 0;
    res_t exp_q[$];
    logic [3:0] out_tags[$];
    int   out_cycs[$];
    int   cyc = 0;
    int   acc_count = 0;
    int   out_count = 0;
    bit   tp_mode = 0;
    bit   stall_prev = 0;
    res_t stall_saved;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference: find the highest set bit, shift it to the MSB, subtract the
    // shift from the exponent with 8-bit wraparound.
    function automatic res_t ref_model(input logic [15:0] m, input logic [7:0] e, input logic [3:0] t);
        res_t r;
        int   lz;
        r.tag = t;
        if (m == 16'h0) begin
            r.zero = 1; r.lz = 5'd16; r.mant = 0; r.exp = 0; r.uflow = 0;
        end else begin
            lz = 0;
            while (m[15 - lz] == 1'b0) lz++;
            r.zero  = 0;
            r.lz    = 5'(lz);
            r.mant  = 16'(m * (2 ** lz));
            r.uflow = (int'(e) < lz);
            r.exp   = 8'((int'(e) - lz + 256) % 256);
`ifdef LZN_FTZ_EN
            if (r.uflow) begin
                r.mant = 0; r.exp = 0;
            end
`endif
        end
        return r;
    endfunction

    // Scoreboard monitor: samples at the falling edge, between active edges.
    always @(negedge clk) begin
        res_t e;
        cyc++;
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_mant", bus.out_mant, stall_saved.mant);
                check("stall_hold_exp",  bus.out_exp,  stall_saved.exp);
                check("stall_hold_tag",  bus.out_tag,  stall_saved.tag);
                check("stall_hold_valid", bus.out_valid, 1);
            end
            if (bus.out_valid && bus.out_ready) begin
                $display("[TB] out tag=%0d mant=%h exp=%0d lz=%0d zero=%0b uflow=%0b",
                         bus.out_tag, bus.out_mant, bus.out_exp, bus.out_lz, bus.out_zero, bus.out_uflow);
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_mant",  bus.out_mant,  e.mant);
                    check("sb_exp",   bus.out_exp,   e.exp);
                    check("sb_lz",    bus.out_lz,    e.lz);
                    check("sb_zero",  bus.out_zero,  e.zero);
                    check("sb_uflow", bus.out_uflow, e.uflow);
                    check("sb_tag",   bus.out_tag,   e.tag);
                end
                out_count++;
                out_tags.push_back(bus.out_tag);
                out_cycs.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(bus.in_mant, bus.in_exp, bus.in_tag));
                acc_count++;
            end
            if (tp_mode) check("tp_in_ready", bus.in_ready, 1);
            stall_prev = bus.out_valid & ~bus.out_ready;
            stall_saved.mant = bus.out_mant;
            stall_saved.exp  = bus.out_exp;
            stall_saved.tag  = bus.out_tag;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_beat(input logic [15:0] m, input logic [7:0] e, input logic [3:0] t);
        int guard;
        guard = 0;
        bus.in_valid = 1; bus.in_mant = m; bus.in_exp = e; bus.in_tag = t;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 0;
    endtask

    task automatic run_single(input string nm, input logic [15:0] m, input logic [7:0] e,
                              input logic [3:0] t, input logic [15:0] xm, input logic [7:0] xe,
                              input logic [4:0] xlz, input logic xz, input logic xu);
        bus.out_ready = 1;
        drive_beat(m, e, t);
        @(negedge clk);
        check({nm, "_lat1_valid"}, bus.out_valid, 0);
        @(negedge clk);
        check({nm, "_valid"}, bus.out_valid, 1);
        check({nm, "_mant"},  bus.out_mant,  xm);
        check({nm, "_exp"},   bus.out_exp,   xe);
        check({nm, "_lz"},    bus.out_lz,    xlz);
        check({nm, "_zero"},  bus.out_zero,  xz);
        check({nm, "_uflow"}, bus.out_uflow, xu);
        check({nm, "_tag"},   bus.out_tag,   t);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rand_mant();
        logic [15:0] r;
        r = 16'($urandom);
        return r >> $urandom_range(0, 16);
    endfunction

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check(nm, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        rst_n = 0;
        bus.in_valid = 0; bus.in_mant = 0; bus.in_exp = 0; bus.in_tag = 0;
        bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_mant",  bus.out_mant,  0);
        check("rst_out_exp",   bus.out_exp,   0);
        check("rst_out_lz",    bus.out_lz,    0);
        check("rst_out_zero",  bus.out_zero,  0);
        check("rst_out_uflow", bus.out_uflow, 0);
        check("rst_out_tag",   bus.out_tag,   0);
        rst_n = 1;
        @(posedge clk); #1;

        // Directed beats
        run_single("single", 16'h0123, 8'd20, 4'd3, 16'h9180, 8'd13, 5'd7, 0, 0);
        run_single("zero",   16'h0000, 8'd50, 4'd9, 16'h0000, 8'd0, 5'd16, 1, 0);
`ifdef LZN_FTZ_EN
        run_single("uflow",  16'h0001, 8'd10, 4'd5, 16'h0000, 8'h00, 5'd15, 0, 1);
`else
        run_single("uflow",  16'h0001, 8'd10, 4'd5, 16'h8000, 8'hFB, 5'd15, 0, 1);
`endif
        run_single("msb_set", 16'h8001, 8'd0, 4'd1, 16'h8001, 8'd0, 5'd0, 0, 0);
        run_single("exp_eq_lz", 16'h0100, 8'd7, 4'd2, 16'h8000, 8'd0, 5'd7, 0, 0);

        // Back-pressure: six beats against a stalled consumer
        bus.out_ready = 0;
        base = out_count;
        fork
            begin
                for (int t = 0; t < 6; t++) drive_beat(rand_mant(), 8'($urandom), 4'(t));
            end
            begin
                int acc_base;
                acc_base = acc_count;
                repeat (5) @(negedge clk);
                check("bp_in_ready",  bus.in_ready, 0);
                check("bp_accepted",  acc_count - acc_base, 2);
                check("bp_out_valid", bus.out_valid, 1);
                check("bp_out_tag",   bus.out_tag, 0);
                @(posedge clk); #1;
                bus.out_ready = 1;
            end
        join
        drain("bp_drain");
        check("bp_out_count", out_count - base, 6);
        for (int i = 0; i < 6 && base + i < out_tags.size(); i++)
            check("bp_order", out_tags[base + i], 4'(i));

        // Full throughput with random data
        bus.out_ready = 1;
        base = out_count;
        tp_mode = 1;
        for (int i = 0; i < 100; i++) drive_beat(rand_mant(), 8'($urandom), 4'($urandom));
        tp_mode = 0;
        drain("tp_drain");
        check("tp_out_count", out_count - base, 100);
        if (out_cycs.size() >= 100)
            check("tp_one_per_cycle", out_cycs[out_cycs.size()-1] - out_cycs[out_cycs.size()-100], 99);

        // Reset with two beats in flight
        base = out_count;
        drive_beat(16'h00F0, 8'd30, 4'd6);
        drive_beat(16'h0F00, 8'd40, 4'd7);
        rst_n = 0;
        #1;
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_in_ready",  bus.in_ready,  1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            check("mrst_no_stale", bus.out_valid, 0);
            check("mrst_in_ready_rel", bus.in_ready, 1);
        end
        check("mrst_out_tag", bus.out_tag, 0);
        check("mrst_out_count", out_count - base, 0);
        @(posedge clk); #1;
        run_single("post_rst", 16'h0030, 8'd100, 4'd12, 16'hC000, 8'd90, 5'd10, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
